regfile_wr_arb: RTL
===================

# regfile_wr_arb

Write-port arbiter and scheduler for the 32x32 general-purpose register file. It merges three write sources onto the register file's single write port (`we`/`waddr`/`wdata`):
- the main pipeline write-back stage, which cannot be back-pressured;
- two multi-cycle secondary units (A: divider, B: load/miss unit), which use valid/ready handshakes.

It registers the selected write and bounds secondary-unit starvation by requesting a one-cycle pipeline stall. It sits between MEM/WB and `regfile`.

## Interface
- `AW`, 5: register address width.
- `DW`, 32: data width.
- `MAX_WAIT`, 4: cycles a secondary request may wait before a stall is forced (range 1..15).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `p_we`  in  1  pipeline write-back enable.
- `p_waddr`  in  AW  pipeline destination register.
- `p_wdata`  in  DW  pipeline write data.
- `a_valid`  in  1  unit A write request.
- `a_waddr`  in  AW  unit A destination register.
- `a_wdata`  in  DW  unit A write data.
- `a_ready`  out  1  unit A accepted this cycle (combinational).
- `b_valid`, `b_waddr`, `b_wdata`, `b_ready`: same as A, for unit B.
- `stall_req`  out  1  registered request to hold the pipeline for one cycle.
- `we`  out  1  register file write enable (registered).
- `waddr`  out  AW  register file write address (registered).
- `wdata`  out  DW  register file write data (registered).

## Operation
Grant selection runs each cycle while `rst`=1, in this priority order:
1. `stall_req`=1: `p_we` is ignored (the pipeline contract forbids write-back during a stall). The secondary grant goes to the requester whose wait counter is at `MAX_WAIT`. If both are at `MAX_WAIT`, the round-robin pointer picks.
2. `p_we`=1: the pipeline wins. `a_ready`=`b_ready`=0.
3. Otherwise, among valid secondaries: a single valid requester is granted. If both are valid, the round-robin pointer picks.

Round-robin pointer:
- 1 bit, reset value = A.
- After any secondary grant, the pointer points to the other unit.

Handshake:
- A transfer occurs when `x_valid`=1 and `x_ready`=1.
- At most one `ready` is high per cycle.
- `ready` never asserts without the matching `valid`.
- Requesters hold valid, address and data stable until accepted.

Register 0:
- A write to address 0 from any source is accepted and consumed (ready=1 for secondaries).
- It produces `we`=0 in the next cycle.

Wait counters (one per unit, 4 bits, saturating at `MAX_WAIT`):
- Increment in each cycle with `valid`=1 and `ready`=0.
- Clear on grant or when `valid`=0.

Stall request:
- `stall_req` next = (either counter == `MAX_WAIT`) AND `stall_req`=0.
- It is therefore a single-cycle pulse with at least one low cycle between pulses.

Reset (`rst`=0 at a rising edge):
- `we`=0, `waddr`=0, `wdata`=0, `stall_req`=0.
- Counters = 0, pointer = A.
- `a_ready`=`b_ready`=0 while `rst`=0.
- An in-flight secondary request is neither accepted nor written; the requester re-presents it after reset.

## Timing
- Latency: a source granted in cycle t appears on `we`/`waddr`/`wdata` in cycle t+1. The register file commits it at the edge ending t+1.
- Registered outputs: `we`, `waddr`, `wdata`, `stall_req`.
- Combinational outputs: `a_ready`, `b_ready` (from inputs and state only; no input-to-input loop).
- Stall timing: a starving request waiting `MAX_WAIT` cycles gets `stall_req` on the next cycle and is granted in that same cycle. Worst-case wait is `MAX_WAIT`+1 cycles.
- With no grant, `we`=0 next cycle. `waddr`/`wdata` keep their previous values.
- Simultaneous `p_we` with both `a_valid` and `b_valid` outside a stall: the pipeline is granted and both counters increment.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with all inputs active. Required: `we`=0, `stall_req`=0, both ready=0 throughout. After release, first grant goes to A when A and B are both valid.
- Pipeline priority: `p_we`=1, `p_waddr`=5, `p_wdata`=0x1234 plus `a_valid`=1. Required: `a_ready`=0 and next cycle `we`=1, `waddr`=5, `wdata`=0x1234.
- Round-robin: A (r3=0xAAAA) and B (r4=0xBBBB) valid continuously, `p_we`=0. Required: grants alternate A, B, A…. Writes r3, r4 appear on consecutive cycles.
- Starvation: `p_we`=1 every cycle, `a_valid`=1 (r7=0x77), `MAX_WAIT`=4. Required: `stall_req`=1 in the 6th cycle, `a_ready`=1 in that cycle, `we`/`waddr`=7 next cycle, and `stall_req`=0 on the following cycle.
- Register 0: `b_valid`=1, `b_waddr`=0, `b_wdata`=0xFFFF. Required: `b_ready`=1, next cycle `we`=0.
- Reset mid-request: `a_valid` waiting 2 cycles, then `rst`=0 for 1 cycle. Required: counters cleared, no write issued. After release A is granted normally.

Source files
------------

// File: rtl/regfile_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arb
// Description : Merges pipeline write-back and two handshaked secondary units
//               onto the single register-file write port, with bounded wait.
// Revision    : 1.0
// ============================================================================
module regfile_wr_arb #(
    parameter int AW       = 5,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p_we,
    input  logic [AW-1:0] p_waddr,
    input  logic [DW-1:0] p_wdata,
    input  logic          a_valid,
    input  logic [AW-1:0] a_waddr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_waddr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ready,
    output logic          stall_req,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata
);

    localparam logic [3:0] C_MAX = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_A    = 2'd2,
        SRC_B    = 2'd3
    } src_t;

    logic [3:0]    r_cnt_a;
    logic [3:0]    r_cnt_b;
    logic          r_ptr;     // 0 = A next, 1 = B next
    logic          r_stall;
    logic          r_we;
    logic [AW-1:0] r_waddr;
    logic [DW-1:0] r_wdata;

    src_t          w_src;
    logic          w_a_starved;
    logic          w_b_starved;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_data;
    logic          w_wr;

    assign w_a_starved = a_valid && (r_cnt_a == C_MAX);
    assign w_b_starved = b_valid && (r_cnt_b == C_MAX);

    // During a stall cycle the pipeline is frozen, so only starved units compete.
    always_comb begin
        w_src = SRC_NONE;
        if (rst) begin
            if (r_stall) begin
                if (w_a_starved && w_b_starved) w_src = r_ptr ? SRC_B : SRC_A;
                else if (w_a_starved)           w_src = SRC_A;
                else if (w_b_starved)           w_src = SRC_B;
            end else if (p_we) begin
                w_src = SRC_PIPE;
            end else if (a_valid && b_valid) begin
                w_src = r_ptr ? SRC_B : SRC_A;
            end else if (a_valid) begin
                w_src = SRC_A;
            end else if (b_valid) begin
                w_src = SRC_B;
            end
        end
    end

    always_comb begin
        w_sel_addr = p_waddr;
        w_sel_data = p_wdata;
        case (w_src)
            SRC_A: begin
                w_sel_addr = a_waddr;
                w_sel_data = a_wdata;
            end
            SRC_B: begin
                w_sel_addr = b_waddr;
                w_sel_data = b_wdata;
            end
            default: begin
                w_sel_addr = p_waddr;
                w_sel_data = p_wdata;
            end
        endcase
    end

    // Writes to r0 are consumed but never reach the register file.
    assign w_wr    = (w_src != SRC_NONE) && (w_sel_addr != '0);
    assign a_ready = (w_src == SRC_A);
    assign b_ready = (w_src == SRC_B);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt_a <= 4'd0;
            r_cnt_b <= 4'd0;
            r_ptr   <= 1'b0;
            r_stall <= 1'b0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_wr;
            if (w_wr) begin
                r_waddr <= w_sel_addr;
                r_wdata <= w_sel_data;
            end
            r_stall <= ((r_cnt_a == C_MAX) || (r_cnt_b == C_MAX)) && !r_stall;

            if (!a_valid || a_ready)   r_cnt_a <= 4'd0;
            else if (r_cnt_a >= C_MAX) r_cnt_a <= C_MAX;
            else                       r_cnt_a <= r_cnt_a + 4'd1;

            if (!b_valid || b_ready)   r_cnt_b <= 4'd0;
            else if (r_cnt_b >= C_MAX) r_cnt_b <= C_MAX;
            else                       r_cnt_b <= r_cnt_b + 4'd1;

            if (w_src == SRC_A)      r_ptr <= 1'b1;
            else if (w_src == SRC_B) r_ptr <= 1'b0;
        end
    end

    assign stall_req = r_stall;
    assign we        = r_we;
    assign waddr     = r_waddr;
    assign wdata     = r_wdata;

endmodule
`default_nettype wire
